// File: rtl/traffic_intersection_ctrl_pkg.sv
// Shared phase encodings, default timings, and the lamp decode for the intersection controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      RED_A = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      RED_B = 3'd5,
      WALK  = 3'd6,
      BAD   = 3'd7
   } phase_e;

   localparam int DEF_GREEN_T  = 5;
   localparam int DEF_YELLOW_T = 2;
   localparam int DEF_ALLRED_T = 1;
   localparam int DEF_WALK_T   = 4;
   localparam int DEF_CNT_W    = 4;

   typedef struct packed {
      logic ns_green;
      logic ns_yellow;
      logic ns_red;
      logic ew_green;
      logic ew_yellow;
      logic ew_red;
      logic walk;
   } lamps_t;

   // Duration in cycles of each phase; the illegal code gets a single cycle.
   function automatic int phase_dur(phase_e ph, int g, int y, int ar, int wk);
      case (ph)
         NS_G, EW_G:   return g;
         NS_Y, EW_Y:   return y;
         RED_A, RED_B: return ar;
         WALK:         return wk;
         default:      return 1;
      endcase
   endfunction

   // Lamp pattern for a phase; anything unexpected shows all-red.
   function automatic lamps_t lamp_decode(phase_e ph);
      lamps_t l;
      l = '0;
      case (ph)
         NS_G:    begin l.ns_green  = 1'b1; l.ew_red = 1'b1; end
         NS_Y:    begin l.ns_yellow = 1'b1; l.ew_red = 1'b1; end
         EW_G:    begin l.ns_red = 1'b1; l.ew_green  = 1'b1; end
         EW_Y:    begin l.ns_red = 1'b1; l.ew_yellow = 1'b1; end
         WALK:    begin l.ns_red = 1'b1; l.ew_red = 1'b1; l.walk = 1'b1; end
         default: begin l.ns_red = 1'b1; l.ew_red = 1'b1; end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// Sensor inputs, lamp outputs and status of the intersection controller.
interface traffic_intersection_ctrl_if #(parameter int CNT_W = 4);
   logic             ew_car;
   logic             ped_btn;
   logic             ns_green, ns_yellow, ns_red;
   logic             ew_green, ew_yellow, ew_red;
   logic             walk;
   logic             ped_ack;
   logic [2:0]       phase;
   logic [CNT_W-1:0] cnt;

   modport master (
      output ew_car, ped_btn,
      input  ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red,
      input  walk, ped_ack, phase, cnt
   );

   modport slave (
      input  ew_car, ped_btn,
      output ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red,
      output walk, ped_ack, phase, cnt
   );
endinterface

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// Single counter timing every phase; can saturate at its limit for the rest state.
module phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             sat_en,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] cnt,
   output logic             expired
);

   logic [CNT_W-1:0] r_cnt;

   assign expired = (r_cnt == limit);
   assign cnt     = r_cnt;

   // Restart on a phase change, hold at the limit when saturating, else count up.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    r_cnt <= '0;
      else if (clear)                r_cnt <= '0;
      else if (!(sat_en && expired)) r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer with a pedestrian all-red walk phase.
module traffic_intersection_ctrl
   import traffic_pkg::*;
#(
   parameter int GREEN_T  = DEF_GREEN_T,
   parameter int YELLOW_T = DEF_YELLOW_T,
   parameter int ALLRED_T = DEF_ALLRED_T,
   parameter int WALK_T   = DEF_WALK_T,
   parameter int CNT_W    = DEF_CNT_W
) (
   input logic                  clk,
   input logic                  reset,
   traffic_intersection_ctrl_if.slave bus
);

   phase_e           r_state, w_nxt;
   logic             r_ew_pend, r_ped_pend, r_ped_ack;
   lamps_t           r_lamps;
   logic [CNT_W-1:0] w_cnt, w_limit;
   logic             w_expired, w_change;

   assign w_limit  = CNT_W'(phase_dur(r_state, GREEN_T, YELLOW_T, ALLRED_T, WALK_T) - 1);
   assign w_change = (w_nxt != r_state);

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_change),
      .sat_en  (r_state == NS_G),
      .limit   (w_limit),
      .cnt     (w_cnt),
      .expired (w_expired)
   );

   // Next phase: NS green rests until something is pending, other phases advance on expiry.
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         NS_G:    if (w_expired && (r_ew_pend || r_ped_pend)) w_nxt = NS_Y;
         NS_Y:    if (w_expired) w_nxt = RED_A;
         RED_A:   if (w_expired) w_nxt = r_ped_pend ? WALK : EW_G;
         EW_G:    if (w_expired) w_nxt = EW_Y;
         EW_Y:    if (w_expired) w_nxt = RED_B;
         RED_B:   if (w_expired) w_nxt = r_ped_pend ? WALK : NS_G;
         WALK:    if (w_expired) w_nxt = r_ew_pend ? EW_G : NS_G;
         default: w_nxt = NS_G;
      endcase
   end

   // State, request latches and registered outputs; a request is consumed on entry to its service.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= NS_G;
         r_ew_pend  <= 1'b0;
         r_ped_pend <= 1'b0;
         r_ped_ack  <= 1'b0;
         r_lamps    <= lamp_decode(NS_G);
      end else begin
         r_state    <= w_nxt;
         r_ew_pend  <= (r_ew_pend  | bus.ew_car)  & (w_nxt != EW_G) & (r_state != EW_G);
         r_ped_pend <= (r_ped_pend | bus.ped_btn) & (w_nxt != WALK) & (r_state != WALK);
         r_ped_ack  <= (w_nxt == WALK) && (r_state != WALK);
         r_lamps    <= lamp_decode(w_nxt);
      end
   end

   assign bus.ns_green  = r_lamps.ns_green;
   assign bus.ns_yellow = r_lamps.ns_yellow;
   assign bus.ns_red    = r_lamps.ns_red;
   assign bus.ew_green  = r_lamps.ew_green;
   assign bus.ew_yellow = r_lamps.ew_yellow;
   assign bus.ew_red    = r_lamps.ew_red;
   assign bus.walk      = r_lamps.walk;
   assign bus.ped_ack   = r_ped_ack;
   assign bus.phase     = r_state;
   assign bus.cnt       = w_cnt;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: spec-derived vector tables, corner sequences, random vs model.
module tb_traffic_intersection_ctrl;

   localparam int CW = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   traffic_intersection_ctrl_if #(.CNT_W(CW)) bus();

   traffic_intersection_ctrl #(
      .GREEN_T(5), .YELLOW_T(2), .ALLRED_T(1), .WALK_T(4), .CNT_W(CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Phase order 0..6 = NS_G NS_Y RED_A EW_G EW_Y RED_B WALK
   int         dur     [7] = '{5, 2, 1, 5, 2, 1, 4};
   logic [6:0] lamp_of [7] = '{7'b1000010, 7'b0100010, 7'b0010010, 7'b0011000,
                               7'b0010100, 7'b0010010, 7'b0010011};

   wire [6:0] lamps = {bus.ns_green, bus.ns_yellow, bus.ns_red,
                       bus.ew_green, bus.ew_yellow, bus.ew_red, bus.walk};

   // ---------------- reference model ----------------
   int m_ph, m_el, m_nph;
   bit m_ewp, m_pdp, m_ack;

   function automatic int rule_next(int ph, bit ewp, bit pdp);
      case (ph)
         0:       return (ewp || pdp) ? 1 : 0;
         1:       return 2;
         2:       return pdp ? 6 : 3;
         3:       return 4;
         4:       return 5;
         5:       return pdp ? 6 : 0;
         default: return ewp ? 3 : 0;
      endcase
   endfunction

   function automatic int next_of(int ph, int el, bit ewp, bit pdp);
      return (el == dur[ph] - 1) ? rule_next(ph, ewp, pdp) : ph;
   endfunction

   assign m_nph = next_of(m_ph, m_el, m_ewp, m_pdp);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ph <= 0; m_el <= 0; m_ewp <= 0; m_pdp <= 0; m_ack <= 0;
      end else begin
         m_ph  <= m_nph;
         m_el  <= (m_nph != m_ph) ? 0 :
                  (m_ph == 0 && m_el == dur[0] - 1) ? m_el : m_el + 1;
         m_ewp <= (m_ewp | bus.ew_car)  && m_nph != 3 && m_ph != 3;
         m_pdp <= (m_pdp | bus.ped_btn) && m_nph != 6 && m_ph != 6;
         m_ack <= (m_nph == 6) && (m_ph != 6);
      end
   end

   // Safety invariant every cycle: one lamp per road, never two roads non-red, walk only all-red.
   always @(negedge clk) begin
      chk("safety",
          int'($onehot({bus.ns_green, bus.ns_yellow, bus.ns_red}) &&
               $onehot({bus.ew_green, bus.ew_yellow, bus.ew_red}) &&
               (bus.ns_red || bus.ew_red) &&
               (!bus.walk || (bus.ns_red && bus.ew_red))), 1);
   end

   // ---------------- vector tables ----------------
   typedef struct {
      bit ew;
      bit ped;
      int ph;
      int cnt;
      bit ack;
   } vec_t;

   vec_t tbl[$];

   task automatic add_run(input int ph, input int len);
      for (int i = 0; i < len; i++) tbl.push_back('{0, 0, ph, i, (ph == 6 && i == 0)});
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.ew_car = 1'b0;
      bus.ped_btn = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_table(input string name);
      do_reset();
      foreach (tbl[i]) begin
         bus.ew_car  = tbl[i].ew;
         bus.ped_btn = tbl[i].ped;
         chk($sformatf("%s[%0d].phase", name, i), int'(bus.phase), tbl[i].ph);
         chk($sformatf("%s[%0d].cnt", name, i), int'(bus.cnt), tbl[i].cnt);
         chk($sformatf("%s[%0d].ack", name, i), int'(bus.ped_ack), int'(tbl[i].ack));
         chk($sformatf("%s[%0d].lamps", name, i), int'(lamps), int'(lamp_of[tbl[i].ph]));
         @(negedge clk);
      end
      bus.ew_car  = 1'b0;
      bus.ped_btn = 1'b0;
   endtask

   initial begin
      int acks, walks, ewg;
      bus.ew_car  = 1'b0;
      bus.ped_btn = 1'b0;

      // Reset state while reset is held
      repeat (2) @(negedge clk);
      chk("rst.phase", int'(bus.phase), 0);
      chk("rst.cnt", int'(bus.cnt), 0);
      chk("rst.ack", int'(bus.ped_ack), 0);
      chk("rst.lamps", int'(lamps), int'(7'b1000010));

      // Idle: rest in NS green, counter saturates at GREEN_T-1
      do_reset();
      for (int n = 0; n < 50; n++) begin
         chk($sformatf("idle[%0d].phase", n), int'(bus.phase), 0);
         chk($sformatf("idle[%0d].cnt", n), int'(bus.cnt), (n < 4) ? n : 4);
         chk($sformatf("idle[%0d].lamps", n), int'(lamps), int'(7'b1000010));
         @(negedge clk);
      end

      // EW car pulse at cycle 0
      tbl.delete();
      add_run(0, 5); add_run(1, 2); add_run(2, 1); add_run(3, 5);
      add_run(4, 2); add_run(5, 1); add_run(0, 3);
      tbl[0].ew = 1;
      run_table("car");

      // Pedestrian only
      tbl.delete();
      add_run(0, 5); add_run(1, 2); add_run(2, 1); add_run(6, 4); add_run(0, 3);
      tbl[0].ped = 1;
      run_table("ped");

      // Pedestrian and car together: walk first, EW request survives the walk
      tbl.delete();
      add_run(0, 5); add_run(1, 2); add_run(2, 1); add_run(6, 4); add_run(3, 5);
      add_run(4, 2); add_run(5, 1); add_run(0, 3);
      tbl[0].ew = 1; tbl[0].ped = 1;
      run_table("both");

      // Button held through WALK: one ack, one walk
      do_reset();
      acks = 0; walks = 0;
      for (int n = 0; n < 40; n++) begin
         bus.ped_btn = (n <= 11);
         if (bus.ped_ack) acks++;
         if (bus.phase == 3'd6) walks++;
         @(negedge clk);
      end
      bus.ped_btn = 1'b0;
      chk("ped_held.acks", acks, 1);
      chk("ped_held.walk_cycles", walks, 4);

      // Car held through EW green: no re-service
      do_reset();
      ewg = 0;
      for (int n = 0; n < 40; n++) begin
         bus.ew_car = (n <= 12);
         if (bus.phase == 3'd3) ewg++;
         @(negedge clk);
      end
      bus.ew_car = 1'b0;
      chk("car_held.ewg_cycles", ewg, 5);
      chk("car_held.final_phase", int'(bus.phase), 0);

      // Reset during EW_Y, with a pedestrian request pending that must be lost
      do_reset();
      for (int n = 0; n < 13; n++) begin
         bus.ew_car  = (n == 0);
         bus.ped_btn = (n == 9);
         @(negedge clk);
      end
      bus.ew_car = 1'b0; bus.ped_btn = 1'b0;
      chk("midrst.pre_phase", int'(bus.phase), 4);
      reset = 1'b0;
      #1;
      chk("midrst.phase", int'(bus.phase), 0);
      chk("midrst.cnt", int'(bus.cnt), 0);
      chk("midrst.lamps", int'(lamps), int'(7'b1000010));
      @(negedge clk);
      reset = 1'b1;
      for (int n = 0; n < 15; n++) begin
         chk($sformatf("midrst.after[%0d].phase", n), int'(bus.phase), 0);
         @(negedge clk);
      end

      // Random traffic against the reference model, with occasional resets
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         chk("rand.phase", int'(bus.phase), m_ph);
         chk("rand.cnt", int'(bus.cnt), m_el);
         chk("rand.ack", int'(bus.ped_ack), int'(m_ack));
         chk("rand.lamps", int'(lamps), int'(lamp_of[m_ph]));
         bus.ew_car  = ($urandom_range(0, 7) == 0);
         bus.ped_btn = ($urandom_range(0, 11) == 0);
         reset       = ($urandom_range(0, 499) != 0);
         @(negedge clk);
         reset = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Sequences a two-road intersection: north-south (NS, the main road) and east-west (EW, the side road), plus a pedestrian all-red WALK phase.
- NS rests in green. EW and pedestrians are served only when a latched request exists.
- Per-phase durations are parameters; a single phase counter times every phase.
- Moore outputs drive the lamp and walk-signal drivers directly; `phase` and `cnt` are exported for status and debug.

Parameters:
- GREEN_T, 5: green duration in cycles; NS minimum green, EW fixed green.
- YELLOW_T, 2: yellow duration in cycles.
- ALLRED_T, 1: all-red clearance in cycles.
- WALK_T, 4: pedestrian walk duration in cycles.
- CNT_W, 4: phase counter width. Every *_T must satisfy 1 <= T <= 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- ew_car  input  1  EW vehicle sensor, level, sampled each cycle
- ped_btn  input  1  pedestrian button, level or pulse, sampled each cycle
- ns_green, ns_yellow, ns_red  output  1 each  NS lamps, exactly one high
- ew_green, ew_yellow, ew_red  output  1 each  EW lamps, exactly one high
- walk  output  1  pedestrian walk lamp
- ped_ack  output  1  one-cycle pulse: pedestrian request accepted
- phase  output  3  current state encoding
- cnt  output  CNT_W  cycles elapsed in the current phase

Behaviour:
- Reset (async, active-low):
  - state=NS_G, cnt=0, ew_pend=0, ped_pend=0, ped_ack=0.
  - Lamps: ns_green=1, ew_red=1, all other lamps and walk=0.
- States and encodings: NS_G=0, NS_Y=1, RED_A=2, EW_G=3, EW_Y=4, RED_B=5, WALK=6. Code 7 is illegal and recovers to NS_G with cnt=0 on the next edge.
- A phase "expires" when cnt == T-1 for that phase's duration.
- Transitions:
  - NS_G: leaves when expired AND (ew_pend | ped_pend), going to NS_Y. Otherwise it stays; cnt saturates at GREEN_T-1 (rest state).
  - NS_Y: expired -> RED_A.
  - RED_A: expired -> WALK if ped_pend, else EW_G.
  - EW_G: expired -> EW_Y (fixed length, no extension).
  - EW_Y: expired -> RED_B.
  - RED_B: expired -> WALK if ped_pend, else NS_G.
  - WALK: expired -> EW_G if ew_pend, else NS_G.
- Counter:
  - cnt <= 0 on the edge that changes state.
  - Otherwise cnt <= cnt+1, except the NS_G saturation above.
- Pending latches: pend_next = (pend | input) & ~entering & ~in_state.
  - ew_pend: input is ew_car; entering/in_state refer to EW_G. A car seen during EW_G is not latched.
  - ped_pend: input is ped_btn; entering/in_state refer to WALK. A button press during WALK is not latched.
  - A press on the same edge as entry is consumed by that service.
- ped_ack is registered: high during the first WALK cycle only.
- Lamp outputs are a pure decode of state:
  - NS_G: ns_green, ew_red.
  - NS_Y: ns_yellow, ew_red.
  - EW_G: ns_red, ew_green.
  - EW_Y: ns_red, ew_yellow.
  - RED_A, RED_B, WALK: ns_red, ew_red. WALK also drives walk=1.
- Safety invariant, every cycle: never any non-red lamp on both roads at once; walk=1 only when both roads are red.
- Reset asserted mid-phase returns immediately to the reset values. Pending requests are lost.

Decomposition:
- Package traffic_pkg holds:
  - phase encodings (NS_G..WALK, width 3);
  - default timing constants;
  - a function mapping phase to its duration.
- One sub-module, phase_timer, instantiated once:
  - Inputs: clk, reset, clear, sat_en, limit.
  - Outputs: cnt, expired.
- The FSM, pending latches and output decode stay in the top module.

Test Plan (defaults; "cycle n" = n-th rising edge after reset release):
- Idle: no inputs for 50 cycles -> NS_G throughout, ns_green=1, ew_red=1, cnt saturates at 4.
- ew_car pulse at cycle 0 -> NS_G cycles 0-4, NS_Y 5-6, RED_A 7, EW_G 8-12, EW_Y 13-14, RED_B 15, NS_G from 16; ew_pend clears on entry to EW_G.
- ped_btn at cycle 0 with no car -> NS_Y 5-6, RED_A 7, WALK 8-11 with ped_ack=1 only at 8, NS_G from 12.
- ped_btn and ew_car both at cycle 0 -> WALK 8-11, then EW_G 12-16 (ew_pend preserved across WALK).
- ped_btn held high through WALK -> exactly one ped_ack, no second WALK; ew_car held through EW_G -> no EW re-service.
- Reset asserted during EW_Y -> next sampled cycle shows ns_green=1, ew_red=1, cnt=0. Throughout all tests an assertion checks the safety invariant and lamp one-hot per road.
